imem_fetch_arbiter: RTL and testbench

IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_rr_arb.sv | 43 ++++
 rtl/imem_fetch_arbiter.sv | 139 +++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared sizing and FSM encoding for the instruction-memory fetch arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_pkg;

  localparam int WORD_LEN = 16;
  localparam int CELL_W   = 4;
  localparam int MEM_SIZE = 64;
  localparam int ADDR_W   = $clog2(MEM_SIZE);
  localparam int BEATS    = WORD_LEN / CELL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-way round-robin arbiter between the fetch port and the loader port.
// Latency: combinational grant; last-grant flag updates on the granting edge.
// Backpressure: grants only while i_en is high; a losing request simply waits.
module imem_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_fetch,
  input  logic i_req_load,
  output logic o_gnt_fetch,
  output logic o_gnt_load
);

  // 1 when the fetch side received the most recent grant
  logic r_last_fetch;

  // Grant the lone requester; on contention grant the side that did not win last
  always_comb begin
    o_gnt_fetch = 1'b0;
    o_gnt_load  = 1'b0;
    if (i_en) begin
      if (i_req_fetch && i_req_load) begin
        o_gnt_fetch = !r_last_fetch;
        o_gnt_load  = r_last_fetch;
      end else begin
        o_gnt_fetch = i_req_fetch;
        o_gnt_load  = i_req_load;
      end
    end
  end

  // Remember the last winner; reset pretends fetch won so the loader goes first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_fetch <= 1'b1;
    end else if (o_gnt_fetch) begin
      r_last_fetch <= 1'b1;
    end else if (o_gnt_load) begin
      r_last_fetch <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates a multi-beat instruction fetch and single-cell loader writes onto one memory port.
// Latency: fetch accepted at edge N returns fetch_valid in cycle N+5; load writes in cycle N+1.
// Backpressure: requests are levels; fetch_ready / load_ack mark acceptance, losers keep waiting.
module imem_fetch_arbiter #(
  parameter int  WORD_LEN = imem_pkg::WORD_LEN,
  parameter int  CELL_W   = imem_pkg::CELL_W,
  parameter int  MEM_SIZE = imem_pkg::MEM_SIZE,
  localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic [WORD_LEN-1:0] fetch_addr,
  output logic                fetch_ready,
  output logic                fetch_valid,
  output logic [WORD_LEN-1:0] fetch_instr,
  input  logic                load_req,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [CELL_W-1:0]   load_data,
  output logic                load_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [CELL_W-1:0]   mem_wdata,
  input  logic [CELL_W-1:0]   mem_rdata,
  output logic                busy
);
  import imem_pkg::*;

  localparam int N_BEATS = WORD_LEN / CELL_W;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [ADDR_W:0] MEM_SIZE_W = (ADDR_W + 1)'(MEM_SIZE);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_W-1:0]          r_base;
  logic [BEAT_W-1:0]          r_beat;
  logic [ADDR_W-1:0]          r_load_addr;
  logic [CELL_W-1:0]          r_load_data;
  logic [WORD_LEN-CELL_W-1:0] r_partial;
  logic [WORD_LEN-1:0]        r_instr;
  logic                       r_valid;
  logic                       w_idle;
  logic                       w_gnt_fetch;
  logic                       w_gnt_load;
  logic                       w_last_beat;
  logic [ADDR_W:0]            w_addr_sum;
  logic [ADDR_W-1:0]          w_beat_addr;
  logic                       w_unused_addr_hi;

  // Upper fetch address bits carry no meaning for this memory
  assign w_unused_addr_hi = ^fetch_addr[WORD_LEN-1:ADDR_W];

  assign w_idle      = (r_state == IDLE);
  assign w_last_beat = (r_beat == BEAT_W'(N_BEATS - 1));
  // base + beat, wrapped modulo MEM_SIZE so non-power-of-two sizes also wrap to 0
  assign w_addr_sum  = {1'b0, r_base} + (ADDR_W + 1)'(r_beat);
  assign w_beat_addr = ADDR_W'((w_addr_sum >= MEM_SIZE_W) ? (w_addr_sum - MEM_SIZE_W) : w_addr_sum);

  assign fetch_ready = w_gnt_fetch;
  assign fetch_valid = r_valid;
  assign fetch_instr = r_instr;
  assign load_ack    = (r_state == LOAD);
  assign busy        = !w_idle;

  imem_rr_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_idle),
    .i_req_fetch (fetch_req),
    .i_req_load  (load_req),
    .o_gnt_fetch (w_gnt_fetch),
    .o_gnt_load  (w_gnt_load)
  );

  // Next-state and memory-port drive; memory port is parked at 0 outside FETCH/LOAD
  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_fetch) begin
          w_state_nxt = FETCH;
        end else if (w_gnt_load) begin
          w_state_nxt = LOAD;
        end
      end
      FETCH: begin
        mem_addr = w_beat_addr;
        if (w_last_beat) begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        mem_addr    = r_load_addr;
        mem_we      = 1'b1;
        mem_wdata   = r_load_data;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request capture, and beat assembly; instr only updates once all beats are in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_beat      <= '0;
      r_load_addr <= '0;
      r_load_data <= '0;
      r_partial   <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (w_gnt_fetch) begin
        r_base <= fetch_addr[ADDR_W-1:0];
        r_beat <= '0;
      end
      if (w_gnt_load) begin
        r_load_addr <= load_addr;
        r_load_data <= load_data;
      end
      if (r_state == FETCH) begin
        r_beat <= r_beat + 1'b1;
        if (w_last_beat) begin
          r_instr <= {r_partial, mem_rdata};
          r_valid <= 1'b1;
        end else begin
          r_partial <= {r_partial[WORD_LEN-2*CELL_W-1:0], mem_rdata};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench: directed scenarios plus randomized fetch/load traffic vs a word-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_fetch_arbiter;

  localparam int WL = 16;
  localparam int CW = 4;
  localparam int MS = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic [WL-1:0] fetch_addr = '0;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [WL-1:0] fetch_instr;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [CW-1:0] load_data = '0;
  logic          load_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Memory the DUT talks to, and the model's own view of what it should contain
  logic [CW-1:0] tb_mem  [MS];
  logic [CW-1:0] ref_mem [MS];
  // Model of the round-robin rule: did fetch win the most recent grant?
  bit last_fetch = 1'b1;

  imem_fetch_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected instruction: four consecutive cells from base, first cell in the top nibble
  function automatic logic [WL-1:0] model_word(input int b);
    logic [WL-1:0] w;
    w = '0;
    for (int k = 0; k < WL / CW; k++) w = {w[WL-CW-1:0], ref_mem[(b + k) % MS]};
    return w;
  endfunction

  // Follow a fetch granted at the coming edge through cycles N+1..N+5
  task automatic fetch_run(input int base, input bit hold, input int load_at, input int la, input int ld);
    logic [WL-1:0] exp;
    exp = model_word(base);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) fetch_req = hold;
      if (load_at == k + 1) begin
        load_req  = 1'b1;
        load_addr = AW'(la);
        load_data = CW'(ld);
      end
      chk("beat_addr", mem_addr, (base + k) % MS);
      chk("beat_we", mem_we, 0);
      chk("beat_rdy", fetch_ready, 0);
      chk("beat_vld", fetch_valid, 0);
      chk("beat_busy", busy, 1);
    end
    @(negedge clk);
    chk("fetch_vld", fetch_valid, 1);
    chk("fetch_instr", fetch_instr, exp);
    chk("fetch_busy", busy, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_addr", mem_addr, 0);
    fetch_req  = 1'b0;
    last_fetch = 1'b1;
  endtask

  // Wait (bounded) for the load_ack of a pending load and check the write it performs
  task automatic load_run(input int la, input int ld, input int exp_wait);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!load_ack && waited < 12);
    chk("load_wait", waited, exp_wait);
    chk("load_we", mem_we, 1);
    chk("load_addr", mem_addr, la);
    chk("load_wdata", mem_wdata, ld);
    chk("load_busy", busy, 1);
    ref_mem[la] = CW'(ld);
    load_req   = 1'b0;
    last_fetch = 1'b0;
    @(negedge clk);
    chk("ack_pulse", load_ack, 0);
  endtask

  task automatic do_load(input int la, input int ld);
    load_req  = 1'b1;
    load_addr = AW'(la);
    load_data = CW'(ld);
    load_run(la, ld, 1);
  endtask

  task automatic do_fetch(input int base, input bit hold);
    fetch_req  = 1'b1;
    fetch_addr = {10'($urandom), AW'(base)};
    #1 chk("fetch_rdy", fetch_ready, 1);
    fetch_run(base, hold, 0, 0, 0);
  endtask

  // Both requesters raised together: the model decides who must win
  task automatic do_both(input int fb, input int la, input int ld);
    bit exp_fetch;
    exp_fetch  = !last_fetch;
    fetch_req  = 1'b1;
    fetch_addr = {10'($urandom), AW'(fb)};
    load_req   = 1'b1;
    load_addr  = AW'(la);
    load_data  = CW'(ld);
    #1 chk("rr_rdy", fetch_ready, 32'(exp_fetch));
    if (exp_fetch) begin
      fetch_run(fb, 1'b0, 0, 0, 0);
      load_run(la, ld, 1);
    end else begin
      load_run(la, ld, 1);
      chk("rr_fetch_next", fetch_ready, 1);
      fetch_run(fb, 1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int i = 0; i < MS; i++) begin
      tb_mem[i]  = CW'($urandom);
      ref_mem[i] = tb_mem[i];
    end

    // Reset values
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_vld", fetch_valid, 0);
    chk("rst_instr", fetch_instr, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    last_fetch = 1'b1;

    // After reset the loader wins the first contention; the next one goes to it again
    do_both(30, 40, 5);
    do_both(40, 41, 6);

    // Cells 8..11 = 3,7,0,9 then fetch 8
    do_load(8, 3);
    do_load(9, 7);
    do_load(10, 0);
    do_load(11, 9);
    do_fetch(8, 1'b0);
    chk("instr_3709", fetch_instr, 32'h3709);
    do_load(20, 1);
    chk("instr_hold", fetch_instr, 32'h3709);

    // Wrap from 63 to 0
    do_load(62, 4'hF);
    do_load(63, 4'h1);
    do_load(0, 4'h2);
    do_load(1, 4'hE);
    do_fetch(62, 1'b0);
    chk("instr_F12E", fetch_instr, 32'hF12E);

    // Reset asserted during beat 2 aborts the fetch
    fetch_req  = 1'b1;
    fetch_addr = 16'd20;
    #1 chk("abort_rdy", fetch_ready, 1);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_instr", fetch_instr, 0);
    chk("abort_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    last_fetch = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fetch_valid) cnt++;
    end
    chk("abort_no_vld", cnt, 0);
    do_both(12, 50, 9);

    // Load raised in cycle N+2 of a fetch waits until N+6
    fetch_req  = 1'b1;
    fetch_addr = 16'd33;
    #1 chk("mid_rdy", fetch_ready, 1);
    fetch_run(33, 1'b0, 2, 34, 11);
    load_run(34, 11, 1);
    do_fetch(33, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: do_load($urandom_range(0, MS - 1), $urandom_range(0, 15));
        1: do_fetch($urandom_range(0, MS - 1), 1'($urandom_range(0, 1)));
        default: do_both($urandom_range(0, MS - 1), $urandom_range(0, MS - 1), $urandom_range(0, 15));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
